subbytes_folded_engine: RTL and testbench

- Time-multiplexed AES SubBytes / InvSubBytes engine for area-constrained datapaths, e.g. the GHASH key-derivation path.
- Processes an N_BYTES state through N_SBOX substitution lanes over N_BYTES/N_SBOX passes.
- Supports a per-block forward/inverse mode and an optional lane output register.
- Uses a valid/ready handshake on both sides so it can sit between stalling pipeline stages.

---
 rtl/subbytes_folded_engine_if.sv | 24 ++
 rtl/subbytes_folded_engine.sv | 218 +++++++++++++++++++++
 tb/tb_subbytes_folded_engine.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/subbytes_folded_engine_if.sv
// Block-level handshake bundle for the folded SubBytes engine.
// The engine attaches through the slave modport; the producer/consumer side uses master.
interface subbytes_folded_engine_if #(
   parameter int NB_BYTE = 8,
   parameter int N_BYTES = 16
) ();
   logic [N_BYTES*NB_BYTE-1:0] i_state;
   logic                       i_valid;
   logic                       i_inverse;
   logic                       o_ready;
   logic [N_BYTES*NB_BYTE-1:0] o_state;
   logic                       o_valid;
   logic                       i_ready;

   modport slave (
      input  i_state, i_valid, i_inverse, i_ready,
      output o_ready, o_state, o_valid
   );

   modport master (
      output i_state, i_valid, i_inverse, i_ready,
      input  o_ready, o_state, o_valid
   );
endinterface

// File: rtl/subbytes_folded_engine.sv
// Time-multiplexed AES SubBytes / InvSubBytes engine.
// N_SBOX lanes walk the buffered state in N_BYTES/N_SBOX passes and assemble the result in place.
module subbytes_folded_engine #(
   parameter int NB_BYTE         = 8,
   parameter int N_BYTES         = 16,
   parameter int N_SBOX          = 4,
   parameter int SBOX_LATENCY    = 0,
   parameter int SUPPORT_INVERSE = 1
) (
   input logic                     i_clock,
   input logic                     i_reset_n,
   subbytes_folded_engine_if.slave bus
);
   localparam int PASSES  = N_BYTES / N_SBOX;
   localparam int CNT_W   = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int LANE_W  = N_SBOX * NB_BYTE;
   localparam int STATE_W = N_BYTES * NB_BYTE;
   localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

   if (NB_BYTE != 8) begin : g_bad_byte_width
      $error("subbytes_folded_engine: NB_BYTE must be 8");
   end
   if ((N_SBOX < 1) || ((N_BYTES % N_SBOX) != 0)) begin : g_bad_lane_count
      $error("subbytes_folded_engine: N_SBOX must divide N_BYTES");
   end
   if ((SBOX_LATENCY != 0) && (SBOX_LATENCY != 1)) begin : g_bad_latency
      $error("subbytes_folded_engine: SBOX_LATENCY must be 0 or 1");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // GF(2^8) arithmetic used to fill the constant substitution tables.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] s);
      return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction

   state_t             state, next_state;
   logic [STATE_W-1:0] in_buf, out_reg;
   logic               mode;
   logic [CNT_W-1:0]   cnt;
   logic               feed_done;
   logic               accept, feed_en, last_feed;
   logic [LANE_W-1:0]  lane_in, lane_out;
   logic               wr_en, wr_last;
   logic [LANE_W-1:0]  wr_data;
   logic [CNT_W-1:0]   wr_slice;

   assign accept    = bus.i_valid && bus.o_ready;
   assign feed_en   = (state == BUSY) && !feed_done;
   assign last_feed = feed_en && (cnt == LAST_PASS);

   // NOTE: the tables are constants with no reset; only real state flops are reset.
   logic [7:0] fwd_rom [256];
   for (genvar e = 0; e < 256; e++) begin : g_fwd_rom
      assign fwd_rom[e] = sbox_fwd(8'(e));
   end

   // Pick the slice of the buffered state that the lanes work on this pass.
   always_comb begin
      // NOTE: default first, so every path assigns lane_in and no latch is inferred.
      lane_in = in_buf[LANE_W-1:0];
      for (int p = 0; p < PASSES; p++) begin
         if (cnt == CNT_W'(p)) lane_in = in_buf[p*LANE_W +: LANE_W];
      end
   end

   if (SUPPORT_INVERSE != 0) begin : g_inverse
      logic [7:0] inv_rom [256];
      for (genvar e = 0; e < 256; e++) begin : g_inv_rom
         assign inv_rom[e] = sbox_inv(8'(e));
      end
      for (genvar l = 0; l < N_SBOX; l++) begin : g_lane
         assign lane_out[l*8 +: 8] = mode ? inv_rom[lane_in[l*8 +: 8]] : fwd_rom[lane_in[l*8 +: 8]];
      end
   end else begin : g_forward_only
      for (genvar l = 0; l < N_SBOX; l++) begin : g_lane
         assign lane_out[l*8 +: 8] = fwd_rom[lane_in[l*8 +: 8]];
      end
   end

   if (SBOX_LATENCY == 1) begin : g_pipe
      logic [LANE_W-1:0] pipe_data;
      logic [CNT_W-1:0]  pipe_slice;
      logic              pipe_vld, pipe_last;

      // Register lane results together with the slice they belong to.
      always_ff @(posedge i_clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            pipe_data  <= '0;
            pipe_slice <= '0;
            pipe_vld   <= 1'b0;
            pipe_last  <= 1'b0;
         end else if (accept) begin
            pipe_vld   <= 1'b0;
            pipe_last  <= 1'b0;
         end else begin
            pipe_data  <= lane_out;
            pipe_slice <= cnt;
            pipe_vld   <= feed_en;
            pipe_last  <= last_feed;
         end
      end

      assign wr_en    = pipe_vld;
      assign wr_last  = pipe_vld && pipe_last;
      assign wr_data  = pipe_data;
      assign wr_slice = pipe_slice;
   end else begin : g_no_pipe
      assign wr_en    = feed_en;
      assign wr_last  = last_feed;
      assign wr_data  = lane_out;
      assign wr_slice = cnt;
   end

   // Capture block and mode at acceptance; step the pass counter while feeding.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (!i_reset_n) begin
         in_buf    <= '0;
         mode      <= 1'b0;
         cnt       <= '0;
         feed_done <= 1'b0;
      end else if (accept) begin
         in_buf    <= bus.i_state;
         mode      <= bus.i_inverse && (SUPPORT_INVERSE != 0);
         cnt       <= '0;
         feed_done <= 1'b0;
      end else if (feed_en) begin
         if (cnt == LAST_PASS) feed_done <= 1'b1;
         else                  cnt       <= cnt + 1'b1;
      end
   end

   // Write each finished slice back into its own byte positions.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         out_reg <= '0;
      end else if (accept) begin
         out_reg <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < N_BYTES; k++) begin
            if (CNT_W'(k / N_SBOX) == wr_slice) out_reg[k*8 +: 8] <= wr_data[(k % N_SBOX)*8 +: 8];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= next_state;
   end

   // FSM next-state logic; DONE with a same-edge new block goes straight back to BUSY.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = BUSY;
         BUSY:    if (wr_last) next_state = DONE;
         DONE:    if (bus.i_ready) next_state = bus.i_valid ? BUSY : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs; o_ready never looks at i_valid.
   always_comb begin
      bus.o_ready = 1'b0;
      bus.o_valid = 1'b0;
      case (state)
         IDLE:    bus.o_ready = 1'b1;
         DONE: begin
            bus.o_valid = 1'b1;
            bus.o_ready = bus.i_ready;
         end
         default: ;
      endcase
   end

   assign bus.o_state = out_reg;
endmodule

// File: tb/tb_subbytes_folded_engine.sv
// Scoreboard bench for subbytes_folded_engine: three configurations side by side
// (16/4/0 default, 16 lanes with a lane register and no inverse table, single lane).
module tb_subbytes_folded_engine;
   localparam int ND = 3;
   localparam int NS   [ND] = '{4, 16, 1};
   localparam int SL   [ND] = '{0, 1, 0};
   localparam int SI   [ND] = '{1, 0, 1};
   localparam int LATS [ND] = '{4, 2, 16};

   localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [127:0] ZERO     = '0;
   localparam logic [127:0] ALL63    = {16{8'h63}};
   localparam logic [127:0] ALL53    = {16{8'h53}};
   localparam logic [127:0] ALLED    = {16{8'hed}};
   localparam logic [127:0] ALLFB    = {16{8'hfb}};

   typedef struct {
      logic [127:0] exp;
      int           acc;
   } sb_item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   logic [127:0]       st  [ND];
   logic               vld [ND];
   logic               inv [ND];
   logic               rdy [ND];
   logic [ND-1:0]      o_r;
   logic [ND-1:0]      o_v;
   logic [ND-1:0][127:0] o_st;
   sb_item_t           sb_q [ND][$];
   int                 last_acc [ND];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   for (genvar g = 0; g < ND; g++) begin : g_dut
      subbytes_folded_engine_if ifc ();
      bit seen = 1'b0;

      assign ifc.i_state   = st[g];
      assign ifc.i_valid   = vld[g];
      assign ifc.i_inverse = inv[g];
      assign ifc.i_ready   = rdy[g];
      assign o_r[g]        = ifc.o_ready;
      assign o_v[g]        = ifc.o_valid;
      assign o_st[g]       = ifc.o_state;

      subbytes_folded_engine #(
         .NB_BYTE(8), .N_BYTES(16), .N_SBOX(NS[g]),
         .SBOX_LATENCY(SL[g]), .SUPPORT_INVERSE(SI[g])
      ) dut (
         .i_clock   (clk),
         .i_reset_n (rst_n),
         .bus       (ifc)
      );

      // Monitor: latency on o_valid rise, data and o_ready while presented, pop on handshake.
      always @(negedge clk) begin
         #2;
         if (rst_n) begin
            if (ifc.o_valid) begin
               if (!seen) begin
                  seen = 1'b1;
                  check($sformatf("dut%0d_expected_output", g), 128'(sb_q[g].size() != 0), 128'(1));
                  if (sb_q[g].size() != 0)
                     check($sformatf("dut%0d_latency", g), 128'(cyc - sb_q[g][0].acc), 128'(LATS[g]));
               end
               if (sb_q[g].size() != 0) begin
                  check($sformatf("dut%0d_o_state", g), ifc.o_state, sb_q[g][0].exp);
                  check($sformatf("dut%0d_o_ready_in_done", g), 128'(ifc.o_ready), 128'(ifc.i_ready));
                  if (ifc.i_ready) begin
                     void'(sb_q[g].pop_front());
                     seen = 1'b0;
                  end
               end
            end else if (sb_q[g].size() != 0 && sb_q[g][0].acc <= cyc) begin
               check($sformatf("dut%0d_o_ready_busy", g), 128'(ifc.o_ready), 128'(0));
            end
         end
      end
   end

   // Offer one block; push its expectation when acceptance is certain at the next edge.
   task automatic send(input int g, input logic [127:0] data, input logic inv_in,
                       input logic [127:0] exp, input bit keep, input bit chk_gap);
      int acc;
      sb_item_t it;
      @(negedge clk);
      st[g]  = data;
      inv[g] = inv_in;
      vld[g] = 1'b1;
      acc = -1;
      for (int n = 0; n < 200; n++) begin
         #1;
         if (o_r[g]) begin
            acc    = cyc + 1;
            it.exp = exp;
            it.acc = acc;
            sb_q[g].push_back(it);
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         check($sformatf("dut%0d_accept_timeout", g), 128'(0), 128'(1));
         vld[g] = 1'b0;
         return;
      end
      if (chk_gap) check($sformatf("dut%0d_throughput_gap", g), 128'(acc - last_acc[g]), 128'(LATS[g] + 1));
      last_acc[g] = acc;
      @(posedge clk);
      if (!keep) begin
         // Disturb inputs during BUSY; the engine must ignore them.
         @(negedge clk);
         vld[g] = 1'b0;
         inv[g] = ~inv[g];
         st[g]  = ~st[g];
      end
   endtask

   task automatic wait_drain(input int g);
      for (int n = 0; n < 100 && sb_q[g].size() != 0; n++) @(negedge clk);
      check($sformatf("dut%0d_drain", g), 128'(sb_q[g].size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int g = 0; g < ND; g++) begin
         st[g] = '0; vld[g] = 1'b0; inv[g] = 1'b0; rdy[g] = 1'b1; last_acc[g] = 0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < ND; g++) begin
         check($sformatf("dut%0d_reset_o_valid", g), 128'(o_v[g]), 128'(0));
         check($sformatf("dut%0d_reset_o_state", g), o_st[g], ZERO);
      end
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < ND; g++) check($sformatf("dut%0d_reset_o_ready", g), 128'(o_r[g]), 128'(1));

      // Forward FIPS-197 vector, inverse round trip, all-0x63 inverse.
      send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b0, 1'b0);
      wait_drain(0);
      send(0, FIPS_OUT, 1'b1, FIPS_IN, 1'b0, 1'b0);
      wait_drain(0);
      send(0, ALL63, 1'b1, ZERO, 1'b0, 1'b0);
      wait_drain(0);

      // Back-to-back with i_valid and i_ready held: one block every LAT+1 cycles.
      send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 1'b0);
      send(0, ZERO,    1'b0, ALL63,    1'b1, 1'b1);
      send(0, ALL53,   1'b0, ALLED,    1'b0, 1'b1);
      wait_drain(0);

      // Backpressure: 10 cycles in DONE with a pending input, then same-edge handshake.
      rdy[0] = 1'b0;
      send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b0, 1'b0);
      fork
         send(0, ZERO, 1'b0, ALL63, 1'b0, 1'b0);
         begin
            repeat (14) @(negedge clk);
            rdy[0] = 1'b1;
         end
      join
      wait_drain(0);

      // Asynchronous reset in feed cycle 2 discards the block.
      send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb_q[0].delete();
      #1;
      check("dut0_midreset_o_valid", 128'(o_v[0]), 128'(0));
      check("dut0_midreset_o_state", o_st[0], ZERO);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("dut0_postreset_o_ready", 128'(o_r[0]), 128'(1));
      repeat (8) @(negedge clk);
      send(0, ALL53, 1'b0, ALLED, 1'b0, 1'b0);
      wait_drain(0);

      // 16 lanes with a lane register, no inverse table: i_inverse is ignored.
      send(1, FIPS_IN, 1'b1, FIPS_OUT, 1'b1, 1'b0);
      send(1, ALL63,   1'b1, ALLFB,    1'b0, 1'b1);
      wait_drain(1);

      // Single lane: 16 passes.
      send(2, ALL53, 1'b0, ALLED, 1'b0, 1'b0);
      wait_drain(2);
      send(2, ALLED, 1'b1, ALL53, 1'b0, 1'b0);
      wait_drain(2);

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
